// File: rtl/fifo_sync_unit.sv
// Synchronous FIFO with registered or first-word-fall-through read, occupancy flags and sticky errors.
// Latency: 1 cycle read (fwft=0) / head visible the cycle after the write edge (fwft=1); writes rejected when full, reads when empty.
module fifo_sync_unit #(
    parameter int word_width    = 32,
    parameter int stk_height    = 8,
    parameter int stk_ptr_width = 3,
    parameter int fwft          = 0,
    parameter int afull_level   = 6,
    parameter int aempty_level  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [word_width-1:0]    data_in,
    input  logic                     write,
    input  logic                     read,
    input  logic                     clr_err,
    output logic [word_width-1:0]    data_out,
    output logic                     data_valid,
    output logic                     stk_full,
    output logic                     stk_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [stk_ptr_width:0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam logic [stk_ptr_width-1:0] PTR_LAST = stk_ptr_width'(stk_height - 1);
    localparam logic [stk_ptr_width:0]   CNT_FULL = (stk_ptr_width + 1)'(stk_height);
    localparam logic [stk_ptr_width:0]   CNT_AF   = (stk_ptr_width + 1)'(afull_level);
    localparam logic [stk_ptr_width:0]   CNT_AE   = (stk_ptr_width + 1)'(aempty_level);

    logic [word_width-1:0]    stk_q [stk_height];
    logic [stk_ptr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [stk_ptr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [stk_ptr_width:0]   count_q, count_d;
    logic [word_width-1:0]    dout_q, dout_d;
    logic                     dvalid_q, dvalid_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;
    logic                     wr_acc, rd_acc;
    logic [word_width-1:0]    head;

    assign stk_full     = (count_q == CNT_FULL);
    assign stk_empty    = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    assign wr_acc = write && !stk_full;
    assign rd_acc = read && !stk_empty;
    assign head   = stk_q[rd_ptr_q];

    // In fall-through mode the head is shown directly; zero while empty keeps reset output at 0.
    assign data_out   = (fwft != 0) ? (stk_empty ? '0 : head) : dout_q;
    assign data_valid = (fwft != 0) ? !stk_empty : dvalid_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        dvalid_d = rd_acc;
        ovf_d    = (ovf_q && !clr_err) || (write && stk_full);
        unf_d    = (unf_q && !clr_err) || (read && stk_empty);
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            dout_d   = head;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left out of reset; only the pointers forget it.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            stk_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

endmodule
